// File: rtl/ucaspian_packet_tx.sv
// Host-bound packet encoder: arbitrates fire/time/metric/clear requests from the core
// and serialises each as a byte packet on a valid/ready stream, then pulses the source.
module ucaspian_packet_tx #(
   parameter logic [7:0] OP_FIRE   = 8'h10,
   parameter logic [7:0] OP_TIME   = 8'h20,
   parameter logic [7:0] OP_METRIC = 8'h30,
   parameter logic [7:0] OP_CLEAR  = 8'h40
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  output_fire_addr,
   input  logic        output_fire_waiting,
   output logic        output_fire_sent,
   input  logic [31:0] time_current,
   input  logic        time_update,
   output logic        time_sent,
   input  logic [7:0]  metric_addr,
   input  logic [7:0]  metric_value,
   input  logic        metric_send,
   input  logic        clear_done,
   output logic        ack_sent,
   output logic [7:0]  tx_data,
   output logic        tx_vld,
   input  logic        tx_rdy,
   output logic [7:0]  metric_drop
);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_ACK} state_t;
   typedef enum logic [1:0] {SRC_FIRE, SRC_TIME, SRC_METRIC, SRC_CLEAR} src_t;

   state_t      r_state, w_state_next;
   src_t        r_src, w_src_next;
   logic [7:0]  r_buf [5];
   logic [7:0]  w_buf_next [5];
   logic [2:0]  r_len, w_len_next;
   logic [2:0]  r_idx, w_idx_next;
   logic        r_metric_pend;
   logic [7:0]  r_metric_addr;
   logic [7:0]  r_metric_value;
   logic [7:0]  r_drop;
   logic        w_metric_release;

   assign w_metric_release = (r_state == ST_ACK) && (r_src == SRC_METRIC);

   always_comb begin
      w_state_next = r_state;
      w_src_next   = r_src;
      w_len_next   = r_len;
      w_idx_next   = r_idx;
      for (int i = 0; i < 5; i++) w_buf_next[i] = r_buf[i];
      case (r_state)
         ST_IDLE: begin
            w_idx_next = '0;
            if (clear_done || r_metric_pend || time_update || output_fire_waiting) begin
               for (int i = 0; i < 5; i++) w_buf_next[i] = '0;
               w_state_next = ST_SEND;
               if (clear_done) begin
                  w_src_next    = SRC_CLEAR;
                  w_len_next    = 3'd1;
                  w_buf_next[0] = OP_CLEAR;
               end else if (r_metric_pend) begin
                  w_src_next    = SRC_METRIC;
                  w_len_next    = 3'd3;
                  w_buf_next[0] = OP_METRIC;
                  w_buf_next[1] = r_metric_addr;
                  w_buf_next[2] = r_metric_value;
               end else if (time_update) begin
                  // Time is snapshotted here; later changes do not affect this packet.
                  w_src_next    = SRC_TIME;
                  w_len_next    = 3'd5;
                  w_buf_next[0] = OP_TIME;
                  w_buf_next[1] = time_current[31:24];
                  w_buf_next[2] = time_current[23:16];
                  w_buf_next[3] = time_current[15:8];
                  w_buf_next[4] = time_current[7:0];
               end else begin
                  w_src_next    = SRC_FIRE;
                  w_len_next    = 3'd2;
                  w_buf_next[0] = OP_FIRE;
                  w_buf_next[1] = output_fire_addr;
               end
            end
         end
         ST_SEND: begin
            if (tx_rdy) begin
               if (r_idx == r_len - 3'd1) w_state_next = ST_ACK;
               else                       w_idx_next   = r_idx + 3'd1;
            end
         end
         ST_ACK:  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_src   <= SRC_FIRE;
         r_len   <= '0;
         r_idx   <= '0;
         for (int i = 0; i < 5; i++) r_buf[i] <= '0;
      end else begin
         r_state <= w_state_next;
         r_src   <= w_src_next;
         r_len   <= w_len_next;
         r_idx   <= w_idx_next;
         for (int i = 0; i < 5; i++) r_buf[i] <= w_buf_next[i];
      end
   end

   // A new metric may replace the entry that is being released in this same cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_metric_pend  <= 1'b0;
         r_metric_addr  <= '0;
         r_metric_value <= '0;
         r_drop         <= '0;
      end else if (metric_send) begin
         if (!r_metric_pend || w_metric_release) begin
            r_metric_pend  <= 1'b1;
            r_metric_addr  <= metric_addr;
            r_metric_value <= metric_value;
         end else if (r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
         end
      end else if (w_metric_release) begin
         r_metric_pend <= 1'b0;
      end
   end

   assign tx_vld           = (r_state == ST_SEND);
   assign tx_data          = (r_state == ST_SEND) ? r_buf[r_idx] : 8'h00;
   assign output_fire_sent = (r_state == ST_ACK) && (r_src == SRC_FIRE);
   assign time_sent        = (r_state == ST_ACK) && (r_src == SRC_TIME);
   assign ack_sent         = (r_state == ST_ACK) && (r_src == SRC_CLEAR);
   assign metric_drop      = r_drop;

endmodule

// File: tb/tb_ucaspian_packet_tx.sv
// Bench for ucaspian_packet_tx: queue-based packet model, per-cycle compare, directed + random stimulus.
module tb_ucaspian_packet_tx;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  output_fire_addr = '0;
   logic        output_fire_waiting = 1'b0;
   logic        output_fire_sent;
   logic [31:0] time_current = '0;
   logic        time_update = 1'b0;
   logic        time_sent;
   logic [7:0]  metric_addr = '0;
   logic [7:0]  metric_value = '0;
   logic        metric_send = 1'b0;
   logic        clear_done = 1'b0;
   logic        ack_sent;
   logic [7:0]  tx_data;
   logic        tx_vld;
   logic        tx_rdy = 1'b0;
   logic [7:0]  metric_drop;

   always #5 clk = ~clk;

   ucaspian_packet_tx dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .output_fire_addr    (output_fire_addr),
      .output_fire_waiting (output_fire_waiting),
      .output_fire_sent    (output_fire_sent),
      .time_current        (time_current),
      .time_update         (time_update),
      .time_sent           (time_sent),
      .metric_addr         (metric_addr),
      .metric_value        (metric_value),
      .metric_send         (metric_send),
      .clear_done          (clear_done),
      .ack_sent            (ack_sent),
      .tx_data             (tx_data),
      .tx_vld              (tx_vld),
      .tx_rdy              (tx_rdy),
      .metric_drop         (metric_drop)
   );

   // Reference model: phase 0 = choosing, 1 = bytes outstanding in m_q, 2 = acknowledge cycle.
   // Sources: 1 fire, 2 time, 3 metric, 4 clear.
   int          m_phase = 0;
   int          m_src = 0;
   logic [7:0]  m_q[$];
   bit          m_pend = 0;
   logic [7:0]  m_maddr = '0;
   logic [7:0]  m_mval = '0;
   int          m_drop = 0;
   bit          m_valid = 0;
   int          cyc = 0;
   logic [7:0]  cap_q[$];
   int          cap_cyc[$];
   int          pulse_q[$];
   int          pulse_cyc[$];
   bit          m_rel;
   bit          m_old_pend;

   always @(posedge clk) begin
      cyc++;
      if (!reset_n) begin
         m_phase = 0;
         m_q.delete();
         m_pend  = 0;
         m_drop  = 0;
         m_valid = 1;
      end else if (m_valid) begin
         m_rel      = (m_phase == 2) && (m_src == 3);
         m_old_pend = m_pend;
         if (m_phase == 0) begin
            if (clear_done) begin
               m_src = 4; m_q = {8'h40}; m_phase = 1;
            end else if (m_old_pend) begin
               m_src = 3; m_q = {8'h30, m_maddr, m_mval}; m_phase = 1;
            end else if (time_update) begin
               m_src = 2;
               m_q = {8'h20, time_current[31:24], time_current[23:16], time_current[15:8], time_current[7:0]};
               m_phase = 1;
            end else if (output_fire_waiting) begin
               m_src = 1; m_q = {8'h10, output_fire_addr}; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (tx_rdy) begin
               cap_q.push_back(m_q.pop_front());
               cap_cyc.push_back(cyc);
               if (m_q.size() == 0) begin
                  m_phase = 2;
                  pulse_q.push_back(m_src);
                  pulse_cyc.push_back(cyc);
               end
            end
         end else begin
            m_phase = 0;
         end
         if (metric_send) begin
            if (!m_old_pend || m_rel) begin
               m_pend = 1; m_maddr = metric_addr; m_mval = metric_value;
            end else if (m_drop < 255) begin
               m_drop++;
            end
         end else if (m_rel) begin
            m_pend = 0;
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int rdy_mode = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One cycle: compare DUT outputs against the model, then react like the sources would.
   task automatic tick();
      logic [2:0] exp_p;
      logic [7:0] exp_d;
      @(negedge clk);
      if (m_valid) begin
         exp_p = 3'b000;
         if (m_phase == 2) begin
            if (m_src == 1) exp_p = 3'b001;
            if (m_src == 2) exp_p = 3'b010;
            if (m_src == 4) exp_p = 3'b100;
         end
         exp_d = (m_phase == 1) ? m_q[0] : 8'h00;
         check("tx_vld", tx_vld, (m_phase == 1));
         check("tx_data", tx_data, exp_d);
         check("pulses", {ack_sent, time_sent, output_fire_sent}, exp_p);
         check("metric_drop", metric_drop, m_drop);
      end
      if (output_fire_sent) output_fire_waiting = 1'b0;
      if (time_sent)        time_update = 1'b0;
      if (ack_sent)         clear_done = 1'b0;
      metric_send = 1'b0;
      case (rdy_mode)
         1: tx_rdy = ~tx_rdy;
         2: tx_rdy = ($urandom_range(0, 3) != 0);
         default: ;
      endcase
   endtask

   task automatic drain(input string name, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         if (m_phase == 0 && !m_pend && !clear_done && !time_update && !output_fire_waiting)
            break;
         tick();
      end
      check({name, "_drain_timeout"}, (k < budget), 1);
      tick();
   endtask

   task automatic expect_bytes(input string name, input int s, input logic [7:0] e[$]);
      check({name, "_nbytes"}, cap_q.size() - s, e.size());
      for (int i = 0; i < e.size(); i++)
         if (s + i < cap_q.size()) check({name, "_byte"}, cap_q[s + i], e[i]);
   endtask

   task automatic expect_pulses(input string name, input int p, input int e[$]);
      check({name, "_npulses"}, pulse_q.size() - p, e.size());
      for (int i = 0; i < e.size(); i++)
         if (p + i < pulse_q.size()) check({name, "_pulse_src"}, pulse_q[p + i], e[i]);
   endtask

   initial begin
      int s, p, c0, k;
      logic [7:0] bq[$];
      int pq[$];

      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      check("reset_vld", tx_vld, 0);
      check("reset_data", tx_data, 0);
      check("reset_drop", metric_drop, 0);

      // 1. fire packet, back-to-back bytes, single pulse, no resend
      tx_rdy = 1'b1; rdy_mode = 0;
      s = cap_q.size(); p = pulse_q.size(); c0 = cyc;
      output_fire_addr = 8'h2A; output_fire_waiting = 1'b1;
      drain("t1", 30);
      repeat (5) tick();
      bq = {8'h10, 8'h2A}; expect_bytes("t1", s, bq);
      pq = {1}; expect_pulses("t1", p, pq);
      check("t1_first_byte_cycle", cap_cyc[s], c0 + 2);
      check("t1_second_byte_cycle", cap_cyc[s + 1], c0 + 3);
      check("t1_pulse_cycle", pulse_cyc[p], c0 + 3);

      // 2. time packet with toggling ready; the snapshot ignores later changes
      s = cap_q.size(); p = pulse_q.size();
      time_current = 32'h0102_0304; time_update = 1'b1; rdy_mode = 1;
      tick();
      time_current = 32'hDEAD_BEEF;
      drain("t2", 60);
      bq = {8'h20, 8'h01, 8'h02, 8'h03, 8'h04}; expect_bytes("t2", s, bq);
      pq = {2}; expect_pulses("t2", p, pq);

      // 3. priority: clear > time > fire
      rdy_mode = 0; tx_rdy = 1'b1;
      s = cap_q.size(); p = pulse_q.size();
      time_current = 32'h0A0B_0C0D; output_fire_addr = 8'h55;
      clear_done = 1'b1; time_update = 1'b1; output_fire_waiting = 1'b1;
      drain("t3", 60);
      bq = {8'h40, 8'h20, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h10, 8'h55}; expect_bytes("t3", s, bq);
      pq = {4, 2, 1}; expect_pulses("t3", p, pq);

      // 4. metric overflow while a time packet is stalled
      s = cap_q.size(); p = pulse_q.size();
      tx_rdy = 1'b0;
      time_current = 32'h1122_3344; time_update = 1'b1;
      tick(); tick();
      metric_addr = 8'hA1; metric_value = 8'h5A; metric_send = 1'b1;
      tick();
      metric_addr = 8'hB2; metric_value = 8'h77; metric_send = 1'b1;
      tick(); tick();
      tx_rdy = 1'b1;
      drain("t4", 60);
      bq = {8'h20, 8'h11, 8'h22, 8'h33, 8'h44, 8'h30, 8'hA1, 8'h5A}; expect_bytes("t4", s, bq);
      pq = {2, 3}; expect_pulses("t4", p, pq);
      check("t4_drop_dut", metric_drop, 1);
      check("t4_drop_model", m_drop, 1);

      // 4b. drop counter saturates
      tx_rdy = 1'b0; time_update = 1'b1;
      for (int i = 0; i < 300; i++) begin
         metric_addr = 8'(i); metric_value = 8'(i + 1); metric_send = 1'b1;
         tick();
      end
      check("t4b_drop_sat", metric_drop, 255);
      tx_rdy = 1'b1;
      drain("t4b", 60);

      // 5. reset after the second time byte abandons the packet
      s = cap_q.size(); p = pulse_q.size();
      time_current = 32'hCAFE_BABE; time_update = 1'b1;
      for (k = 0; k < 20 && (cap_q.size() - s) < 2; k++) tick();
      check("t5_wait_timeout", (k < 20), 1);
      reset_n = 1'b0; time_current = 32'h5566_7788;
      tick();
      check("t5_vld_in_reset", tx_vld, 0);
      check("t5_drop_after_reset", metric_drop, 0);
      check("t5_no_time_sent", time_sent, 0);
      reset_n = 1'b1;
      drain("t5", 60);
      bq = {8'h20, 8'hCA, 8'h20, 8'h55, 8'h66, 8'h77, 8'h88}; expect_bytes("t5", s, bq);
      pq = {2}; expect_pulses("t5", p, pq);

      // random traffic
      rdy_mode = 2;
      for (int i = 0; i < 3000; i++) begin
         reset_n = ($urandom_range(0, 599) != 0);
         if (!clear_done && $urandom_range(0, 9) == 0) clear_done = 1'b1;
         if (!time_update && $urandom_range(0, 5) == 0) time_update = 1'b1;
         if (!output_fire_waiting && $urandom_range(0, 4) == 0) begin
            output_fire_waiting = 1'b1;
            output_fire_addr = 8'($urandom);
         end
         time_current = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            metric_send = 1'b1; metric_addr = 8'($urandom); metric_value = 8'($urandom);
         end
         tick();
      end
      reset_n = 1'b1;
      rdy_mode = 0; tx_rdy = 1'b1;
      drain("final", 200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
